extbus_bridge: RTL and testbench

//  Parametrised host-bus front end between the asynchronous 6502-style extbus pins and the clk25 register core.

---
 rtl/extbus_pkg.sv | 24 ++
 rtl/extbus_wfifo.sv | 51 +++++
 rtl/extbus_bridge.sv | 195 +++++++++++++++++++
 tb/tb_extbus_bridge.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/extbus_pkg.sv
// Shared definitions for the extbus host-bus bridge: FSM encoding and a ceil-log2 helper.
package extbus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrAct,
        StRdWait,
        StRdIssue,
        StRdHold
    } bridge_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/extbus_wfifo.sv
// Posted-write FIFO; a push into a full FIFO is accepted when a pop frees the slot in the same cycle.
module extbus_wfifo
    import extbus_pkg::*;
#(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_rdata = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/extbus_bridge.sv
// Host-bus front end: synchronises and filters the async extbus strobes, posts writes to a FIFO
// and issues reads only after all posted writes have drained.
module extbus_bridge
    import extbus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 2,
    parameter int unsigned WFIFO_DEPTH = 4
) (
    input  logic              i_clk25,
    input  logic              i_reset,
    input  logic              i_extbus_cs_n,
    input  logic              i_extbus_rd_n,
    input  logic              i_extbus_wr_n,
    input  logic [ADDR_W-1:0] i_extbus_a,
    input  logic [DATA_W-1:0] i_extbus_d_in,
    output logic [DATA_W-1:0] o_extbus_d_out,
    output logic              o_extbus_d_oe,
    output logic              o_extbus_irq_n,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_rd_strobe,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_irq,
    output logic              o_wr_overflow,
    input  logic              i_ovf_clr
);
    localparam int unsigned CNT_W = clog2(FILTER_LEN + 1);
    localparam int unsigned FW    = ADDR_W + DATA_W;

    logic [2:0][SYNC_STAGES-1:0]        r_sync;
    logic [SYNC_STAGES-1:0][ADDR_W-1:0] r_a_pipe;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] r_d_pipe;
    logic [2:0]                         w_pins;
    logic [2:0]                         w_pins_s;
    logic [1:0]                         w_raw;
    logic [1:0]                         r_filt;
    logic [1:0][CNT_W-1:0]              r_cnt;
    logic [ADDR_W-1:0]                  w_a_al;
    logic [DATA_W-1:0]                  w_d_al;

    assign w_pins = {i_extbus_wr_n, i_extbus_rd_n, i_extbus_cs_n};
    for (genvar g = 0; g < 3; g++) begin : g_sync_out
        assign w_pins_s[g] = r_sync[g][SYNC_STAGES-1];
    end
    // bit 0 = rd, bit 1 = wr
    assign w_raw  = {~w_pins_s[0] & ~w_pins_s[2], ~w_pins_s[0] & ~w_pins_s[1]};
    assign w_a_al = r_a_pipe[SYNC_STAGES-1];
    assign w_d_al = r_d_pipe[SYNC_STAGES-1];

    always_ff @(posedge i_clk25) begin
        if (i_reset) begin
            r_sync   <= '1;
            r_a_pipe <= '0;
            r_d_pipe <= '0;
            r_filt   <= '0;
            r_cnt    <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_pins[i]};
            end
            r_a_pipe <= {r_a_pipe[SYNC_STAGES-2:0], i_extbus_a};
            r_d_pipe <= {r_d_pipe[SYNC_STAGES-2:0], i_extbus_d_in};
            // Filtered level flips only after FILTER_LEN consecutive differing samples.
            for (int j = 0; j < 2; j++) begin
                if (w_raw[j] == r_filt[j]) begin
                    r_cnt[j] <= '0;
                end else if (r_cnt[j] == CNT_W'(FILTER_LEN - 1)) begin
                    r_filt[j] <= w_raw[j];
                    r_cnt[j]  <= '0;
                end else begin
                    r_cnt[j] <= r_cnt[j] + 1'b1;
                end
            end
        end
    end

    bridge_state_e     r_state;
    logic              r_rd_prev, r_wr_prev, r_block, r_first;
    logic              r_rd_strobe, r_d_oe, r_irq_n, r_ovf;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_d_out;
    logic [FW-1:0]     r_shadow;
    logic [FW-1:0]     w_head;
    logic              w_rd_f, w_wr_f, w_rd_rise, w_wr_rise;
    logic              w_push, w_pop, w_full, w_empty;

    assign w_rd_f    = r_filt[0];
    assign w_wr_f    = r_filt[1];
    assign w_rd_rise = w_rd_f & ~r_rd_prev;
    assign w_wr_rise = w_wr_f & ~r_wr_prev;
    assign w_push    = (r_state == StWrAct) && !w_wr_f;
    assign w_pop     = o_wr_valid & i_wr_ready;

    always_ff @(posedge i_clk25) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_rd_prev   <= 1'b0;
            r_wr_prev   <= 1'b0;
            r_block     <= 1'b0;
            r_first     <= 1'b0;
            r_rd_strobe <= 1'b0;
            r_rd_addr   <= '0;
            r_d_out     <= '0;
            r_d_oe      <= 1'b0;
            r_shadow    <= '0;
        end else begin
            r_rd_prev   <= w_rd_f;
            r_wr_prev   <= w_wr_f;
            r_rd_strobe <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // Simultaneous rd/wr is illegal: park until both strobes are released.
                    if (r_block) begin
                        if (!w_rd_f && !w_wr_f) r_block <= 1'b0;
                    end else if (w_rd_rise && w_wr_rise) begin
                        r_block <= 1'b1;
                    end else if (w_wr_rise) begin
                        r_state <= StWrAct;
                    end else if (w_rd_rise) begin
                        r_state <= StRdWait;
                    end
                end
                StWrAct: begin
                    r_shadow <= {w_a_al, w_d_al};
                    if (!w_wr_f) r_state <= StIdle;
                end
                StRdWait: begin
                    if (!w_rd_f) begin
                        r_state <= StIdle;
                    end else if (w_empty) begin
                        r_rd_strobe <= 1'b1;
                        r_rd_addr   <= w_a_al;
                        r_state     <= StRdIssue;
                    end
                end
                StRdIssue: begin
                    r_first <= 1'b1;
                    r_state <= StRdHold;
                end
                StRdHold: begin
                    if (r_first) begin
                        r_first <= 1'b0;
                        r_d_out <= i_rd_data;
                        r_d_oe  <= 1'b1;
                    end else if (!w_rd_f) begin
                        r_d_oe  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk25) begin
        if (i_reset) begin
            r_irq_n <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_irq_n <= ~i_irq;
            r_ovf   <= (w_push && w_full && !w_pop) || (r_ovf && !i_ovf_clr);
        end
    end

    extbus_wfifo #(
        .WIDTH (FW),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .i_clk   (i_clk25),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_wdata (r_shadow),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_wr_valid     = ~w_empty;
    assign o_wr_addr      = w_head[FW-1:DATA_W];
    assign o_wr_data      = w_head[DATA_W-1:0];
    assign o_rd_strobe    = r_rd_strobe;
    assign o_rd_addr      = r_rd_addr;
    assign o_extbus_d_out = r_d_out;
    assign o_extbus_d_oe  = r_d_oe;
    assign o_extbus_irq_n = r_irq_n;
    assign o_wr_overflow  = r_ovf;

endmodule

// File: tb/tb_extbus_bridge.sv
// Directed bench for extbus_bridge: writes, overflow, read ordering, glitches, illegal strobes, reset.
module tb_extbus_bridge;
    logic       clk = 1'b0;
    logic       reset;
    logic       cs_n, rd_n, wr_n;
    logic [4:0] a;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe, irq_n;
    logic       wr_valid, wr_ready;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_strobe;
    logic [4:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       irq, wr_overflow, ovf_clr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] pop_a[$];
    logic [7:0] pop_d[$];
    int         n_strobes   = 0;
    int         strobe_pops = 0;
    logic [4:0] strobe_addr = '0;
    logic       doe_seen    = 1'b0;
    logic       strobe_prev = 1'b0;
    logic [7:0] resp        = 8'hC3;
    int         s0;

    extbus_bridge #(
        .ADDR_W      (5),
        .DATA_W      (8),
        .SYNC_STAGES (2),
        .FILTER_LEN  (2),
        .WFIFO_DEPTH (4)
    ) dut (
        .i_clk25        (clk),
        .i_reset        (reset),
        .i_extbus_cs_n  (cs_n),
        .i_extbus_rd_n  (rd_n),
        .i_extbus_wr_n  (wr_n),
        .i_extbus_a     (a),
        .i_extbus_d_in  (d_in),
        .o_extbus_d_out (d_out),
        .o_extbus_d_oe  (d_oe),
        .o_extbus_irq_n (irq_n),
        .o_wr_valid     (wr_valid),
        .i_wr_ready     (wr_ready),
        .o_wr_addr      (wr_addr),
        .o_wr_data      (wr_data),
        .o_rd_strobe    (rd_strobe),
        .o_rd_addr      (rd_addr),
        .i_rd_data      (rd_data),
        .i_irq          (irq),
        .o_wr_overflow  (wr_overflow),
        .i_ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    // Core model: read data appears in the cycle after rd_strobe only.
    always @(negedge clk) begin
        rd_data     = strobe_prev ? resp : 8'h00;
        strobe_prev = rd_strobe;
    end

    always @(negedge clk) begin
        if (wr_valid && wr_ready) begin
            pop_a.push_back(wr_addr);
            pop_d.push_back(wr_data);
        end
        if (rd_strobe) begin
            n_strobes   = n_strobes + 1;
            strobe_addr = rd_addr;
            strobe_pops = pop_a.size();
        end
        if (d_oe) doe_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic host_write(input logic [4:0] addr, input logic [7:0] data, input int low);
        a    = addr;
        d_in = data;
        cs_n = 1'b0;
        wr_n = 1'b0;
        tick(low);
        wr_n = 1'b1;
        cs_n = 1'b1;
        tick(10);
    endtask

    task automatic wait_doe(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (d_oe) break;
            tick(1);
        end
        check_eq("d_oe_rise", {31'd0, d_oe}, 32'd1);
    endtask

    task automatic clear_mon();
        pop_a.delete();
        pop_d.delete();
        doe_seen = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        a = '0; d_in = '0; wr_ready = 1'b1; irq = 1'b0; ovf_clr = 1'b0;
        tick(3);
        check_eq("rst_d_out", {24'd0, d_out}, 32'h00);
        check_eq("rst_d_oe", {31'd0, d_oe}, 32'd0);
        check_eq("rst_irq_n", {31'd0, irq_n}, 32'd1);
        check_eq("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check_eq("rst_rd_strobe", {31'd0, rd_strobe}, 32'd0);
        check_eq("rst_ovf", {31'd0, wr_overflow}, 32'd0);
        reset = 1'b0;
        tick(4);

        // 1: single posted write
        clear_mon();
        host_write(5'h03, 8'h5A, 6);
        check_eq("t1_pops", pop_a.size(), 32'd1);
        if (pop_a.size() > 0) begin
            check_eq("t1_addr", {27'd0, pop_a[0]}, 32'h03);
            check_eq("t1_data", {24'd0, pop_d[0]}, 32'h5A);
        end
        check_eq("t1_ovf", {31'd0, wr_overflow}, 32'd0);

        // 2: overflow with a stalled core
        clear_mon();
        wr_ready = 1'b0;
        for (int i = 1; i <= 5; i++) host_write(5'(i), 8'(i), 4);
        check_eq("t2_valid", {31'd0, wr_valid}, 32'd1);
        check_eq("t2_head", {24'd0, wr_data}, 32'h01);
        check_eq("t2_ovf_set", {31'd0, wr_overflow}, 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check_eq("t2_ovf_clr", {31'd0, wr_overflow}, 32'd0);
        wr_ready = 1'b1;
        tick(8);
        check_eq("t2_pops", pop_a.size(), 32'd4);
        for (int i = 0; i < 4 && i < pop_d.size(); i++) begin
            check_eq("t2_pop_data", {24'd0, pop_d[i]}, 32'(i + 1));
        end

        // 3: read ordered behind two posted writes
        clear_mon();
        wr_ready = 1'b0;
        host_write(5'h08, 8'h11, 4);
        host_write(5'h09, 8'h22, 4);
        s0   = n_strobes;
        resp = 8'hC3;
        a    = 5'h07;
        cs_n = 1'b0;
        rd_n = 1'b0;
        tick(12);
        check_eq("t3_no_early_strobe", n_strobes - s0, 32'd0);
        wr_ready = 1'b1;
        wait_doe(30);
        check_eq("t3_strobes", n_strobes - s0, 32'd1);
        check_eq("t3_rd_addr", {27'd0, strobe_addr}, 32'h07);
        check_eq("t3_pops_before_rd", strobe_pops, 32'd2);
        check_eq("t3_d_out", {24'd0, d_out}, 32'hC3);
        tick(3);
        check_eq("t3_d_oe_held", {31'd0, d_oe}, 32'd1);
        rd_n = 1'b1;
        cs_n = 1'b1;
        tick(8);
        check_eq("t3_d_oe_off", {31'd0, d_oe}, 32'd0);
        check_eq("t3_d_out_kept", {24'd0, d_out}, 32'hC3);

        // 4: single-cycle glitches are filtered out
        clear_mon();
        s0 = n_strobes;
        cs_n = 1'b0; rd_n = 1'b0; tick(1); rd_n = 1'b1; cs_n = 1'b1; tick(6);
        cs_n = 1'b0; wr_n = 1'b0; tick(1); wr_n = 1'b1; cs_n = 1'b1; tick(8);
        check_eq("t4_strobes", n_strobes - s0, 32'd0);
        check_eq("t4_pops", pop_a.size(), 32'd0);
        check_eq("t4_doe", {31'd0, doe_seen}, 32'd0);

        // 5: rd without cs, then rd+wr together
        clear_mon();
        s0 = n_strobes;
        rd_n = 1'b0; tick(6); rd_n = 1'b1; tick(6);
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; tick(6);
        rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1; tick(10);
        check_eq("t5_strobes", n_strobes - s0, 32'd0);
        check_eq("t5_pops", pop_a.size(), 32'd0);
        check_eq("t5_doe", {31'd0, doe_seen}, 32'd0);
        host_write(5'h1F, 8'hA5, 5);
        check_eq("t5_recover_pops", pop_a.size(), 32'd1);
        if (pop_a.size() > 0) check_eq("t5_recover_data", {24'd0, pop_d[0]}, 32'hA5);

        // 6: reset mid-read, reset with queued write, irq path
        resp = 8'h3C;
        a = 5'h02; cs_n = 1'b0; rd_n = 1'b0;
        wait_doe(20);
        reset = 1'b1;
        tick(1);
        check_eq("t6_doe_reset", {31'd0, d_oe}, 32'd0);
        check_eq("t6_dout_reset", {24'd0, d_out}, 32'h00);
        rd_n = 1'b1; cs_n = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(6);
        check_eq("t6_doe_idle", {31'd0, d_oe}, 32'd0);
        clear_mon();
        wr_ready = 1'b0;
        host_write(5'h04, 8'h77, 5);
        check_eq("t6_queued", {31'd0, wr_valid}, 32'd1);
        reset = 1'b1;
        tick(1);
        check_eq("t6_valid_reset", {31'd0, wr_valid}, 32'd0);
        reset = 1'b0;
        wr_ready = 1'b1;
        tick(5);
        check_eq("t6_discarded", pop_a.size(), 32'd0);
        irq = 1'b1;
        #2;
        check_eq("t6_irq_n_before", {31'd0, irq_n}, 32'd1);
        tick(1);
        check_eq("t6_irq_n_after", {31'd0, irq_n}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
